// File: rtl/tx_arb_ordering_sequencer_if.sv
// Interfaces used by tx_arb_ordering_sequencer.
//
// ordering_if
//   Arbiter <-> ordering checker. The arbiter presents two transactions
//   (first = older, second = younger) with their RO/IDO attributes,
//   requester IDs and the completion kind. The checker answers on
//   ordering_result (1 = the second may pass the first).
//   Trans encoding: 2'b00 P, 2'b01 NP, 2'b10 CPL.
//   Modports: ARBITER_ORDERING_IF (arbiter side), CHECKER_ORDERING_IF.
//
// tx_arb_ordering_sequencer_if
//   Grant handshake to the downstream TLP mux and pop pulses to the queues.
//   Modports: master (arbiter side), slave (mux / queue side).

interface ordering_if #(
    parameter int REQUESTER_ID_WIDTH = 16
);
    logic [1:0]                    first_trans;
    logic [1:0]                    second_trans;
    logic                          first_ro;
    logic                          first_ido;
    logic                          second_ro;
    logic                          second_ido;
    logic [REQUESTER_ID_WIDTH-1:0] first_req_id;
    logic [REQUESTER_ID_WIDTH-1:0] second_req_id;
    logic [2:0]                    comp_typ;
    logic                          ordering_result;

    modport ARBITER_ORDERING_IF (
        output first_trans, second_trans, first_ro, first_ido,
               second_ro, second_ido, first_req_id, second_req_id, comp_typ,
        input  ordering_result
    );

    modport CHECKER_ORDERING_IF (
        input  first_trans, second_trans, first_ro, first_ido,
               second_ro, second_ido, first_req_id, second_req_id, comp_typ,
        output ordering_result
    );
endinterface

interface tx_arb_ordering_sequencer_if;
    logic       grant_valid;
    logic [1:0] grant_src;
    logic       grant_ready;
    logic       p_pop;
    logic       np_pop;
    logic       cpl_pop;

    modport master (
        output grant_valid, grant_src, p_pop, np_pop, cpl_pop,
        input  grant_ready
    );

    modport slave (
        input  grant_valid, grant_src, p_pop, np_pop, cpl_pop,
        output grant_ready
    );
endinterface

// File: rtl/tx_arb_ordering_sequencer.sv
// tx_arb_ordering_sequencer
//   Picks the next TLP source (P / NP / CPL) for the TX arbiter. Heads are
//   snapshotted in IDLE and sorted by arrival age into A (oldest), B, C.
//   A is granted if it has credit; otherwise younger heads may bypass it
//   after the ordering checker approves each pairwise pass, one check per
//   cycle (EVAL_B: A/B, EVAL_CA: A/C, EVAL_CB: B/C).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   {p,np,cpl}_hdr_valid_i   head present (stable until popped)
//   {p,np,cpl}_seq_i         arrival sequence number of the head
//   {p,np,cpl}_ro_i/_ido_i   Attr[1] / Attr[2] of the head
//   {p,np,cpl}_req_id_i      requester / completer ID
//   cpl_comp_typ_i           completion kind of the CPL head
//   {p,np,cpl}_credit_ok_i   head has enough flow-control credit
//   ord                      ordering checker interface (arbiter side)
//   gnt                      grant valid/ready + per-queue pop pulses
//
// Configuration
//   ARB_STARVE_LIMIT_EN : when defined, adds parameter STARVE_MAX and a
//   counter that stops bypassing an uncredited A after STARVE_MAX
//   consecutive bypass grants. When undefined, bypass is unlimited.

module tx_arb_ordering_sequencer #(
    parameter int SEQ_W              = 8,
    parameter int REQUESTER_ID_WIDTH = 16
`ifdef ARB_STARVE_LIMIT_EN
    ,
    parameter int STARVE_MAX         = 8
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p_hdr_valid_i,
    input  logic                          np_hdr_valid_i,
    input  logic                          cpl_hdr_valid_i,
    input  logic [SEQ_W-1:0]              p_seq_i,
    input  logic [SEQ_W-1:0]              np_seq_i,
    input  logic [SEQ_W-1:0]              cpl_seq_i,
    input  logic                          p_ro_i,
    input  logic                          np_ro_i,
    input  logic                          cpl_ro_i,
    input  logic                          p_ido_i,
    input  logic                          np_ido_i,
    input  logic                          cpl_ido_i,
    input  logic [REQUESTER_ID_WIDTH-1:0] p_req_id_i,
    input  logic [REQUESTER_ID_WIDTH-1:0] np_req_id_i,
    input  logic [REQUESTER_ID_WIDTH-1:0] cpl_req_id_i,
    input  logic [2:0]                    cpl_comp_typ_i,
    input  logic                          p_credit_ok_i,
    input  logic                          np_credit_ok_i,
    input  logic                          cpl_credit_ok_i,
    ordering_if.ARBITER_ORDERING_IF       ord,
    tx_arb_ordering_sequencer_if.master   gnt
);

    localparam logic [1:0] SRC_CPL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EVAL_B  = 3'd1,
        ST_EVAL_CA = 3'd2,
        ST_EVAL_CB = 3'd3,
        ST_GRANT   = 3'd4
    } state_e;

    // x is older than y when (y - x) is nonzero with MSB clear; equal
    // numbers fall back to the fixed P > NP > CPL order.
    function automatic logic older_f(input logic [SEQ_W-1:0] x_seq,
                                     input logic [SEQ_W-1:0] y_seq,
                                     input logic             x_first);
        logic [SEQ_W-1:0] diff_s;
        diff_s = y_seq - x_seq;
        if (diff_s != {SEQ_W{1'b0}}) return ~diff_s[SEQ_W-1];
        else                         return x_first;
    endfunction

    function automatic logic [2:0] onehot_f(input logic [1:0] src);
        case (src)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    state_e                        state_q, state_d;
    logic [1:0]                    win_q, win_d;
    logic [2:0]                    popped_q, popped_d;

    // Live head view (source-indexed, entry 3 is a permanently empty slot)
    logic [2:0]                    in_vld_s;
    logic [3:0]                    in_cred_s, in_ro_s, in_ido_s;
    logic [SEQ_W-1:0]              in_seq_s [4];
    logic [REQUESTER_ID_WIDTH-1:0] in_id_s  [4];
    logic [1:0]                    rank_s   [3];
    logic [1:0]                    slot_s   [3];
    logic [1:0]                    nvld_s;

    // Snapshot taken in IDLE
    logic [3:0]                    cred_q, ro_q, ido_q;
    logic [REQUESTER_ID_WIDTH-1:0] id_q     [4];
    logic [1:0]                    slot_q   [3];
    logic [1:0]                    nvld_q;
    logic [2:0]                    comp_typ_q;

    logic                          starve_block_s;

    // Gather head inputs; a source popped last cycle is hidden because its
    // queue head only refreshes one cycle after the pop.
    always_comb begin
        in_vld_s  = {cpl_hdr_valid_i, np_hdr_valid_i, p_hdr_valid_i} & ~popped_q;
        in_cred_s = {1'b0, cpl_credit_ok_i, np_credit_ok_i, p_credit_ok_i};
        in_ro_s   = {1'b0, cpl_ro_i, np_ro_i, p_ro_i};
        in_ido_s  = {1'b0, cpl_ido_i, np_ido_i, p_ido_i};
        in_seq_s[0] = p_seq_i;
        in_seq_s[1] = np_seq_i;
        in_seq_s[2] = cpl_seq_i;
        in_seq_s[3] = {SEQ_W{1'b0}};
        in_id_s[0]  = p_req_id_i;
        in_id_s[1]  = np_req_id_i;
        in_id_s[2]  = cpl_req_id_i;
        in_id_s[3]  = {REQUESTER_ID_WIDTH{1'b0}};
    end

    // Age sort: a head's rank is the number of valid heads older than it.
    always_comb begin
        nvld_s = 2'd0;
        for (int i = 0; i < 3; i++) begin
            rank_s[i] = 2'd0;
            slot_s[i] = 2'b11;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if ((j != i) && in_vld_s[j] && older_f(in_seq_s[j], in_seq_s[i], j < i))
                    rank_s[i] = rank_s[i] + 2'd1;
                else
                    rank_s[i] = rank_s[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (in_vld_s[i]) begin
                slot_s[rank_s[i]] = 2'(i);
                nvld_s            = nvld_s + 2'd1;
            end else begin
                nvld_s = nvld_s;
            end
        end
    end

`ifdef ARB_STARVE_LIMIT_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [1:0]       starve_src_q, starve_src_d;
    logic [SEQ_W-1:0] starve_seq_q, starve_seq_d;
    logic             starve_vld_q, starve_vld_d;
    logic             a_same_s;

    // Track consecutive bypass grants around the same oldest head.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        starve_src_d = starve_src_q;
        starve_seq_d = starve_seq_q;
        starve_vld_d = starve_vld_q;
        a_same_s     = starve_vld_q && (starve_src_q == slot_s[0]) &&
                       (starve_seq_q == in_seq_s[slot_s[0]]);
        starve_block_s = (nvld_s != 2'd0) && a_same_s &&
                         (starve_cnt_q == CNT_W'(STARVE_MAX));
        if ((state_q == ST_IDLE) && (nvld_s != 2'd0) && !a_same_s) begin
            starve_cnt_d = {CNT_W{1'b0}};
            starve_src_d = slot_s[0];
            starve_seq_d = in_seq_s[slot_s[0]];
            starve_vld_d = 1'b1;
        end else if ((state_q == ST_GRANT) && gnt.grant_ready) begin
            if (win_q == slot_q[0])
                starve_cnt_d = {CNT_W{1'b0}};
            else if (starve_cnt_q != CNT_W'(STARVE_MAX))
                starve_cnt_d = starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            else
                starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= {CNT_W{1'b0}};
            starve_src_q <= 2'b00;
            starve_seq_q <= {SEQ_W{1'b0}};
            starve_vld_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_src_q <= starve_src_d;
            starve_seq_q <= starve_seq_d;
            starve_vld_q <= starve_vld_d;
        end
    end
`else
    assign starve_block_s = 1'b0;
`endif

    // Next-state and winner selection.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        popped_d = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (nvld_s == 2'd0) begin
                    state_d = ST_IDLE;
                end else if (in_cred_s[slot_s[0]]) begin
                    state_d = ST_GRANT;
                    win_d   = slot_s[0];
                end else if ((nvld_s >= 2'd2) && !starve_block_s) begin
                    state_d = ST_EVAL_B;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL_B: begin
                if (ord.ordering_result && cred_q[slot_q[1]]) begin
                    state_d = ST_GRANT;
                    win_d   = slot_q[1];
                end else if ((nvld_q == 2'd3) && cred_q[slot_q[2]]) begin
                    state_d = ST_EVAL_CA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL_CA: begin
                if (ord.ordering_result) state_d = ST_EVAL_CB;
                else                     state_d = ST_IDLE;
            end
            ST_EVAL_CB: begin
                if (ord.ordering_result) begin
                    state_d = ST_GRANT;
                    win_d   = slot_q[2];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (gnt.grant_ready) begin
                    state_d  = ST_IDLE;
                    popped_d = onehot_f(win_q);
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, winner and pop-mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            win_q    <= 2'b00;
            popped_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            popped_q <= popped_d;
        end
    end

    // Snapshot registers, refreshed on every IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cred_q     <= 4'b0000;
            ro_q       <= 4'b0000;
            ido_q      <= 4'b0000;
            nvld_q     <= 2'd0;
            comp_typ_q <= 3'b000;
            for (int i = 0; i < 4; i++) id_q[i] <= {REQUESTER_ID_WIDTH{1'b0}};
            for (int i = 0; i < 3; i++) slot_q[i] <= 2'b00;
        end else if (state_q == ST_IDLE) begin
            cred_q     <= in_cred_s;
            ro_q       <= in_ro_s;
            ido_q      <= in_ido_s;
            nvld_q     <= nvld_s;
            comp_typ_q <= cpl_comp_typ_i;
            for (int i = 0; i < 4; i++) id_q[i] <= in_id_s[i];
            for (int i = 0; i < 3; i++) slot_q[i] <= slot_s[i];
        end else begin
            cred_q <= cred_q;
        end
    end

    logic       ord_en_s;
    logic [1:0] ord_f_s, ord_s_s;

    // Ordering-checker operands: only driven in EVAL states, zero otherwise.
    always_comb begin
        ord_en_s = 1'b1;
        ord_f_s  = 2'b00;
        ord_s_s  = 2'b00;
        case (state_q)
            ST_EVAL_B:  begin ord_f_s = slot_q[0]; ord_s_s = slot_q[1]; end
            ST_EVAL_CA: begin ord_f_s = slot_q[0]; ord_s_s = slot_q[2]; end
            ST_EVAL_CB: begin ord_f_s = slot_q[1]; ord_s_s = slot_q[2]; end
            default:    ord_en_s = 1'b0;
        endcase
    end

    assign ord.first_trans   = ord_en_s ? ord_f_s : 2'b00;
    assign ord.second_trans  = ord_en_s ? ord_s_s : 2'b00;
    assign ord.first_ro      = ord_en_s & ro_q[ord_f_s];
    assign ord.first_ido     = ord_en_s & ido_q[ord_f_s];
    assign ord.second_ro     = ord_en_s & ro_q[ord_s_s];
    assign ord.second_ido    = ord_en_s & ido_q[ord_s_s];
    assign ord.first_req_id  = ord_en_s ? id_q[ord_f_s] : {REQUESTER_ID_WIDTH{1'b0}};
    assign ord.second_req_id = ord_en_s ? id_q[ord_s_s] : {REQUESTER_ID_WIDTH{1'b0}};
    assign ord.comp_typ      = (ord_en_s && ((ord_f_s == SRC_CPL) || (ord_s_s == SRC_CPL)))
                               ? comp_typ_q : 3'b000;

    logic [2:0] pop_s;
    assign pop_s = (!rst && (state_q == ST_GRANT) && gnt.grant_ready) ? onehot_f(win_q) : 3'b000;

    assign gnt.grant_valid = (state_q == ST_GRANT);
    assign gnt.grant_src   = win_q;
    assign gnt.p_pop       = pop_s[0];
    assign gnt.np_pop      = pop_s[1];
    assign gnt.cpl_pop     = pop_s[2];

endmodule

// File: tb/tb_tx_arb_ordering_sequencer.sv
module tb_tx_arb_ordering_sequencer;

    localparam int SEQ_W = 8;
    localparam int RIDW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             p_v, np_v, cpl_v;
    logic [SEQ_W-1:0] p_seq, np_seq, cpl_seq;
    logic             p_ro, np_ro, cpl_ro, p_ido, np_ido, cpl_ido;
    logic [RIDW-1:0]  p_id, np_id, cpl_id;
    logic [2:0]       cpl_ct;
    logic             p_cr, np_cr, cpl_cr;

    ordering_if #(.REQUESTER_ID_WIDTH(RIDW)) ord();
    tx_arb_ordering_sequencer_if gnt();

    // Checker model: approval per (first, second) pair, set by each test.
    logic res_tbl [4][4];
    assign ord.ordering_result = res_tbl[ord.first_trans][ord.second_trans];

    tx_arb_ordering_sequencer #(
        .SEQ_W(SEQ_W),
        .REQUESTER_ID_WIDTH(RIDW)
`ifdef ARB_STARVE_LIMIT_EN
        ,
        .STARVE_MAX(2)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .p_hdr_valid_i(p_v), .np_hdr_valid_i(np_v), .cpl_hdr_valid_i(cpl_v),
        .p_seq_i(p_seq), .np_seq_i(np_seq), .cpl_seq_i(cpl_seq),
        .p_ro_i(p_ro), .np_ro_i(np_ro), .cpl_ro_i(cpl_ro),
        .p_ido_i(p_ido), .np_ido_i(np_ido), .cpl_ido_i(cpl_ido),
        .p_req_id_i(p_id), .np_req_id_i(np_id), .cpl_req_id_i(cpl_id),
        .cpl_comp_typ_i(cpl_ct),
        .p_credit_ok_i(p_cr), .np_credit_ok_i(np_cr), .cpl_credit_ok_i(cpl_cr),
        .ord(ord),
        .gnt(gnt)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] sb_q [$];
    logic [1:0] mon_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] src);
        case (src)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Scoreboard: every accepted grant must match the next expected source.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt.grant_valid && gnt.grant_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_grant", 32'd1, 32'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check_eq("sb_src", {30'd0, gnt.grant_src}, {30'd0, mon_exp});
                    check_eq("sb_pop", {29'd0, gnt.cpl_pop, gnt.np_pop, gnt.p_pop},
                             {29'd0, onehot(mon_exp)});
                end
            end else begin
                check_eq("no_pop_without_hs", {29'd0, gnt.cpl_pop, gnt.np_pop, gnt.p_pop}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (!gnt.grant_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        gnt.grant_ready = 1'b1;
        tick();
        gnt.grant_ready = 1'b0;
    endtask

    task automatic clear_heads();
        p_v = 1'b0; np_v = 1'b0; cpl_v = 1'b0;
        p_cr = 1'b0; np_cr = 1'b0; cpl_cr = 1'b0;
        p_ro = 1'b0; np_ro = 1'b0; cpl_ro = 1'b0;
        p_ido = 1'b0; np_ido = 1'b0; cpl_ido = 1'b0;
        cpl_ct = 3'b000;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) res_tbl[i][j] = 1'b0;
        repeat (5) tick();
    endtask

    task automatic check_ord(input string tag, input logic [1:0] f, input logic [1:0] s,
                             input logic [2:0] ct);
        check_eq({tag, "_first"},  {30'd0, ord.first_trans},  {30'd0, f});
        check_eq({tag, "_second"}, {30'd0, ord.second_trans}, {30'd0, s});
        check_eq({tag, "_ctyp"},   {29'd0, ord.comp_typ},     {29'd0, ct});
    endtask

    int n;
    int cnt;

    initial begin
        gnt.grant_ready = 1'b0;
        p_seq = 8'd0; np_seq = 8'd0; cpl_seq = 8'd0;
        p_id = 16'h0000; np_id = 16'h0000; cpl_id = 16'h0000;
        clear_heads();

        // Reset state
        check_eq("rst_gvalid", {31'd0, gnt.grant_valid}, 32'd0);
        check_eq("rst_gsrc",   {30'd0, gnt.grant_src},   32'd0);
        check_ord("rst_ord", 2'b00, 2'b00, 3'b000);
        check_eq("rst_ord_attr", {28'd0, ord.first_ro, ord.first_ido, ord.second_ro, ord.second_ido}, 32'd0);
        check_eq("rst_ord_ids", {ord.first_req_id, ord.second_req_id}, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_idle", {31'd0, gnt.grant_valid}, 32'd0);

        // P oldest with credit, NP behind it
        p_v = 1'b1; p_seq = 8'd5; p_cr = 1'b1;
        np_v = 1'b1; np_seq = 8'd6; np_cr = 1'b1;
        sb_q.push_back(2'b00);
        wait_grant(n);
        check_eq("a_credit_lat", n, 32'd1);
        check_eq("a_credit_src", {30'd0, gnt.grant_src}, 32'd0);
        check_ord("grant_ord_zero", 2'b00, 2'b00, 3'b000);
        sb_q.push_back(2'b01);
        handshake();
        check_eq("idle_after_pop", {31'd0, gnt.grant_valid}, 32'd0);
        tick();
        p_v = 1'b0;   // head refreshes late; the pop mask must hide P
        check_eq("np_2cyc_after_pop", {31'd0, gnt.grant_valid}, 32'd1);
        check_eq("np_src", {30'd0, gnt.grant_src}, 32'd1);
        handshake();
        clear_heads();

        // B bypass: P uncredited, CPL passes
        p_v = 1'b1; p_seq = 8'd5; p_ro = 1'b1; p_id = 16'h1234;
        cpl_v = 1'b1; cpl_seq = 8'd6; cpl_cr = 1'b1; cpl_ido = 1'b1; cpl_id = 16'hABCD;
        cpl_ct = 3'b101;
        res_tbl[0][2] = 1'b1;
        sb_q.push_back(2'b10);
        tick();
        check_ord("evalb_ord", 2'b00, 2'b10, 3'b101);
        check_eq("evalb_attr", {28'd0, ord.first_ro, ord.first_ido, ord.second_ro, ord.second_ido}, 32'b1001);
        check_eq("evalb_ids", {ord.first_req_id, ord.second_req_id}, 32'h1234ABCD);
        wait_grant(n);
        check_eq("b_bypass_lat", n, 32'd1);
        handshake();
        clear_heads();

        // C bypass through EVAL_B (false), EVAL_CA, EVAL_CB
        p_v = 1'b1; p_seq = 8'd10;
        np_v = 1'b1; np_seq = 8'd11; np_cr = 1'b1;
        cpl_v = 1'b1; cpl_seq = 8'd12; cpl_cr = 1'b1; cpl_ct = 3'b010;
        res_tbl[0][2] = 1'b1; res_tbl[1][2] = 1'b1;
        sb_q.push_back(2'b10);
        tick();
        check_ord("c_evalb", 2'b00, 2'b01, 3'b000);
        tick();
        check_ord("c_evalca", 2'b00, 2'b10, 3'b010);
        tick();
        check_ord("c_evalcb", 2'b01, 2'b10, 3'b010);
        tick();
        check_eq("c_bypass_cyc4", {31'd0, gnt.grant_valid}, 32'd1);
        handshake();
        clear_heads();

        // Same, but EVAL_CB refuses: no grant at all
        p_v = 1'b1; p_seq = 8'd10;
        np_v = 1'b1; np_seq = 8'd11; np_cr = 1'b1;
        cpl_v = 1'b1; cpl_seq = 8'd12; cpl_cr = 1'b1;
        res_tbl[0][2] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (gnt.grant_valid) cnt++;
        end
        check_eq("cb_false_no_grant", cnt, 32'd0);
        clear_heads();

        // Sequence wrap and reversed roles
        p_v = 1'b1; p_seq = 8'hFE; p_cr = 1'b1;
        np_v = 1'b1; np_seq = 8'h01; np_cr = 1'b1;
        sb_q.push_back(2'b00); sb_q.push_back(2'b01);
        wait_grant(n);
        check_eq("wrap_p_lat", n, 32'd1);
        check_eq("wrap_p_src", {30'd0, gnt.grant_src}, 32'd0);
        handshake();
        p_v = 1'b0;
        wait_grant(n);
        check_eq("wrap_np_src", {30'd0, gnt.grant_src}, 32'd1);
        handshake();
        clear_heads();

        np_v = 1'b1; np_seq = 8'hFE; np_cr = 1'b1;
        p_v = 1'b1; p_seq = 8'h01; p_cr = 1'b1;
        sb_q.push_back(2'b01); sb_q.push_back(2'b00);
        wait_grant(n);
        check_eq("wrap2_np_src", {30'd0, gnt.grant_src}, 32'd1);
        handshake();
        np_v = 1'b0;
        wait_grant(n);
        handshake();
        clear_heads();

        // Equal sequence numbers: NP wins over CPL
        np_v = 1'b1; np_seq = 8'd7; np_cr = 1'b1;
        cpl_v = 1'b1; cpl_seq = 8'd7; cpl_cr = 1'b1;
        sb_q.push_back(2'b01); sb_q.push_back(2'b10);
        wait_grant(n);
        handshake();
        np_v = 1'b0;
        wait_grant(n);
        handshake();
        clear_heads();

        // Reset while a grant is pending and not accepted
        p_v = 1'b1; p_seq = 8'd30; p_cr = 1'b1;
        wait_grant(n);
        check_eq("pre_rst_grant", {31'd0, gnt.grant_valid}, 32'd1);
        rst = 1'b1;
        check_eq("rst_no_pop", {29'd0, gnt.cpl_pop, gnt.np_pop, gnt.p_pop}, 32'd0);
        tick();
        check_eq("rst_drop_gvalid", {31'd0, gnt.grant_valid}, 32'd0);
        p_v = 1'b0;
        rst = 1'b0;
        tick();
        p_v = 1'b1; p_seq = 8'd31;
        sb_q.push_back(2'b00);
        wait_grant(n);
        check_eq("after_rst_idle_lat", n, 32'd1);
        handshake();
        clear_heads();

`ifdef ARB_STARVE_LIMIT_EN
        // Starvation limit of 2 bypasses around an uncredited P
        p_v = 1'b1; p_seq = 8'd40;
        np_v = 1'b1; np_seq = 8'd41; np_cr = 1'b1;
        res_tbl[0][1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back(2'b01);
            wait_grant(n);
            check_eq("starve_bypass", {31'd0, gnt.grant_valid}, 32'd1);
            handshake();
            np_seq = np_seq + 8'd1;
        end
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (gnt.grant_valid) cnt++;
        end
        check_eq("starve_blocked", cnt, 32'd0);
        p_cr = 1'b1;
        sb_q.push_back(2'b00);
        wait_grant(n);
        check_eq("starve_a_grant", {30'd0, gnt.grant_src}, 32'd0);
        handshake();
        p_v = 1'b0;
        sb_q.push_back(2'b01);
        wait_grant(n);
        handshake();
        clear_heads();
`endif

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
